// File: rtl/tile_pattern_gen_if.sv
// Pattern RAM write port between the tile generator and the playfield RAM.
// The generator drives the master side; the RAM samples the slave side.
interface tile_pattern_gen_if #(
  parameter int LANES = 3,
  parameter int DEPTH = 100
);
  logic                     wr_en;
  logic [$clog2(DEPTH)-1:0] wr_addr;
  logic [LANES-1:0]         wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/tile_pattern_gen.sv
// Tile pattern generator: streams DEPTH one-hot lane rows from an LFSR into the
// playfield RAM, then tracks row progress and level number for the game FSM.
module tile_pattern_gen #(
  parameter int          LANES     = 3,
  parameter int          DEPTH     = 100,
  parameter int          MAX_LEVEL = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       StartGame,
  input  logic                       is_GameOver,
  input  logic                       correct_key,
  tile_pattern_gen_if.master         ram,
  output logic                       busy,
  output logic [7:0]                 game,
  output logic [$clog2(DEPTH+1)-1:0] row_counter,
  output logic                       level_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (LANES <= 2) ? 1 : $clog2(LANES);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, GEN, PLAY, DONE} state_t;

  state_t         state, state_next;
  logic [15:0]    lfsr;
  logic [AW-1:0]  row_idx, row_idx_next;
  logic [LW-1:0]  prev_lane, prev_lane_next;
  logic [LW-1:0]  raw, lane;
  logic [7:0]     game_next;
  logic [CW-1:0]  row_counter_next;
  logic           level_clear_next;
  logic           accept;
  logic           wr_en_c;
  logic [AW-1:0]  wr_addr_c;
  logic [LANES-1:0] wr_data_c;

  // Out-of-range or repeated picks fall through to the next lane, which keeps
  // rows one-hot and guarantees no two consecutive rows share a lane.
  always_comb begin
    raw = lfsr[LW-1:0];
    if (({1'b0, raw} >= (LW+1)'(LANES)) || (raw == prev_lane))
      lane = (prev_lane == LW'(LANES - 1)) ? '0 : prev_lane + 1'b1;
    else
      lane = raw;
  end

  always_comb begin
    state_next       = state;
    row_idx_next     = row_idx;
    prev_lane_next   = prev_lane;
    game_next        = game;
    row_counter_next = row_counter;
    level_clear_next = 1'b0;
    wr_en_c          = 1'b0;
    wr_addr_c        = '0;
    wr_data_c        = '0;
    busy             = 1'b0;
    accept           = StartGame && (state != GEN);

    case (state)
      GEN: begin
        wr_en_c        = 1'b1;
        busy           = 1'b1;
        wr_addr_c      = row_idx;
        wr_data_c      = LANES'(1) << lane;
        prev_lane_next = lane;
        if (row_idx == AW'(DEPTH - 1))
          state_next = PLAY;
        else
          row_idx_next = row_idx + 1'b1;
      end
      PLAY: begin
        if (correct_key) begin
          if (row_counter == CW'(DEPTH - 1)) begin
            row_counter_next = CW'(DEPTH);
            level_clear_next = 1'b1;
            state_next       = DONE;
          end else begin
            row_counter_next = row_counter + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A new level request beats any same-cycle row clear, including the last one.
    if (accept) begin
      if (is_GameOver)
        game_next = 8'd1;
      else if (game < 8'(MAX_LEVEL))
        game_next = game + 8'd1;
      row_counter_next = '0;
      row_idx_next     = '0;
      prev_lane_next   = LW'(LANES - 1);
      level_clear_next = 1'b0;
      state_next       = GEN;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= IDLE;
      lfsr        <= SEED_EFF;
      row_idx     <= '0;
      prev_lane   <= LW'(LANES - 1);
      game        <= '0;
      row_counter <= '0;
      level_clear <= 1'b0;
    end else begin
      state       <= state_next;
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      row_idx     <= row_idx_next;
      prev_lane   <= prev_lane_next;
      game        <= game_next;
      row_counter <= row_counter_next;
      level_clear <= level_clear_next;
    end
  end

  assign ram.wr_en   = wr_en_c;
  assign ram.wr_addr = wr_addr_c;
  assign ram.wr_data = wr_data_c;

endmodule

// File: doc/tile_pattern_gen.md
Name: tile_pattern_gen

Overview:
- Parametrised successor to the fixed 3-lane / 100-row tile generator.
- Generates DEPTH rows of one-hot lane patterns from an internal LFSR and streams them, one row per cycle, to the playfield pattern RAM over a write port.
- Tracks game level and player row progress, and signals level completion.
- Sits between the game-control FSM (StartGame, is_GameOver, correct_key) and the playfield RAM / renderer.

Parameters:
- LANES, 3, number of lanes; row width; legal range 2..8.
- DEPTH, 100, rows per level; legal range 2..1024.
- MAX_LEVEL, 4, highest game level; game saturates here.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk, in, 1, system clock.
- Reset, in, 1, synchronous active-high reset.
- StartGame, in, 1, request a new level. Level-sensitive; sampled every cycle.
- is_GameOver, in, 1, qualifies StartGame as a restart from level 1.
- correct_key, in, 1, player cleared the current row; single-cycle pulse.
- wr_en, out, 1, pattern RAM write strobe.
- wr_addr, out, $clog2(DEPTH), row address of the write.
- wr_data, out, LANES, one-hot lane pattern.
- busy, out, 1, high while rows are being generated.
- game, out, 8, current level number.
- row_counter, out, $clog2(DEPTH+1), rows cleared this level.
- level_clear, out, 1, one-cycle pulse when the last row is cleared.

Behaviour:
- Reset and synchronicity:
  - One clock; reset is synchronous and active-high.
  - Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, game=0, row_counter=0, level_clear=0, lfsr=SEED (0 replaced by 1).
  - Reset overrides everything, including a generation in progress; no further writes follow it.
- LFSR:
  - 16-bit Fibonacci, shift left; new bit0 = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - Advances every non-reset cycle, in all states, so start timing varies the pattern.
- States:
  - IDLE: no writes.
  - GEN: emits rows.
  - PLAY: counts correct_key.
  - DONE: level cleared; waits for StartGame.
- StartGame accept:
  - Accepted in IDLE, PLAY and DONE; ignored in GEN.
  - On accept, game is updated as follows:
    - game <= 1 if is_GameOver=1;
    - otherwise game <= game+1 if game < MAX_LEVEL;
    - otherwise game is unchanged.
  - Also on accept: row_counter <= 0, row index <= 0, prev_lane <= LANES-1, state <= GEN.
- GEN timing:
  - If StartGame is accepted at cycle T, rows are written on cycles T+1 .. T+DEPTH.
  - wr_en=1 on each of those cycles; wr_addr runs 0 .. DEPTH-1.
  - busy is high for exactly the same cycles.
  - At T+DEPTH+1: state=PLAY, wr_en=0, busy=0.
- Lane pick, per row:
  - LW = max(1, $clog2(LANES)); raw = lfsr[LW-1:0].
  - If raw >= LANES or raw == prev_lane, then lane = (prev_lane+1) mod LANES; otherwise lane = raw.
  - wr_data = 1 << lane; prev_lane <= lane.
  - Consequence: consecutive rows never repeat a lane, and wr_data is always exactly one-hot.
- PLAY:
  - Each correct_key increments row_counter.
  - When the pulse arrives with row_counter == DEPTH-1: row_counter <= DEPTH, level_clear=1 for one cycle, state <= DONE.
  - correct_key is ignored in IDLE, GEN and DONE, and never exceeds DEPTH.
- Simultaneous events:
  - StartGame and correct_key in the same PLAY cycle: StartGame wins; row_counter=0.
  - StartGame and the final correct_key in the same cycle: StartGame wins; no level_clear.

Test Plan:
- LANES=3, DEPTH=8, SEED=16'hACE1, Reset, then StartGame for 1 cycle at T -> wr_en high T+1..T+8, wr_addr 0..7, every wr_data in {001,010,100}, no two consecutive equal, busy low at T+9, game=1.
- LANES=5, DEPTH=16 -> wr_data always one-hot within 5 bits, never 0, no lane >= 5; results match a bit-accurate LFSR model row for row.
- StartGame held high during GEN -> no restart; exactly DEPTH writes. A second accept in PLAY -> game 2; repeat up to MAX_LEVEL=4, then game stays 4.
- In PLAY with DEPTH=8, 8 correct_key pulses -> row_counter 1..8, level_clear exactly once on the 8th pulse; a 9th pulse leaves row_counter=8.
- is_GameOver=1 with StartGame while game=3 -> game=1, row_counter=0, new GEN burst of DEPTH rows.
- Reset asserted at the 4th GEN write -> following cycle wr_en=0, busy=0, game=0, lfsr=SEED; no further writes.
